// File: rtl/floor_request_dispatcher.sv
// Purpose: latches floor calls, picks a SCAN-ordered target floor and times the door dwell on arrival.
// Latency: button to pending 1 cycle; pending to busy 1 cycle; busy to requested_floor 1 more cycle.
// Backpressure: none; the controller follows requested_floor. Optional FLOOR_CALL_CANCEL_EN makes repeat presses cancel calls.
module floor_request_dispatcher #(
  parameter int DWELL_TICKS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [3:0] call_btn,
  input  logic [3:0] present_floor,
  output logic [3:0] requested_floor,
  output logic [3:0] pending,
  output logic       direction,
  output logic       busy,
  output logic       door_open
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MOVE  = 2'd1,
    DWELL = 2'd2
  } state_t;

  localparam logic [3:0] DWELL_LOAD = 4'(DWELL_TICKS);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] btn_q;
  logic [3:0] rise;
  logic [3:0] clr;
  logic [3:0] cancel_mask;
  logic [3:0] pending_nxt;
  logic [3:0] dwell_cnt;
  logic [3:0] dwell_cnt_nxt;
  logic [3:0] req_nxt;
  logic       dir_nxt;

  logic       floor_valid;
  logic [3:0] below_mask;
  logic [3:0] above_mask;
  logic [3:0] above;
  logic [3:0] below;
  logic [3:0] near_above;
  logic [3:0] near_below;
  logic [3:0] target;
  logic       target_dir;
  logic       target_found;
  logic       at_call;
  logic       arrived;
  logic       reopen;

  // Floor decode: exactly one bit set, and masks of floors strictly below/above it.
  assign floor_valid = (present_floor != 4'b0000) &&
                       ((present_floor & (present_floor - 4'd1)) == 4'b0000);
  assign below_mask  = present_floor - 4'd1;
  assign above_mask  = ~(below_mask | present_floor);
  assign above       = pending & above_mask;
  assign below       = pending & below_mask;

  assign rise    = call_btn & ~btn_q;
  assign at_call = floor_valid && ((pending & present_floor) != 4'b0000);
  // Requested already equals present on the first MOVE cycle, so arrival also needs a live call here.
  assign arrived = at_call && (present_floor == requested_floor);
  assign reopen  = (rise & present_floor) != 4'b0000;

  assign busy      = (state != IDLE);
  assign door_open = (state == DWELL);

  // Nearest pending floor above (lowest set bit) and below (highest set bit).
  always_comb begin
    near_above = 4'b0000;
    near_below = 4'b0000;
    for (int i = 3; i >= 0; i--) begin
      if (above[i]) near_above = 4'b0001 << i;
    end
    for (int i = 0; i < 4; i++) begin
      if (below[i]) near_below = 4'b0001 << i;
    end
  end

  // SCAN choice: keep going while calls remain ahead, otherwise turn around.
  always_comb begin
    target       = 4'b0000;
    target_dir   = direction;
    target_found = 1'b0;
    if (floor_valid) begin
      if (direction) begin
        if (above != 4'b0000) begin
          target       = near_above;
          target_dir   = 1'b1;
          target_found = 1'b1;
        end else if (below != 4'b0000) begin
          target       = near_below;
          target_dir   = 1'b0;
          target_found = 1'b1;
        end
      end else begin
        if (below != 4'b0000) begin
          target       = near_below;
          target_dir   = 1'b0;
          target_found = 1'b1;
        end else if (above != 4'b0000) begin
          target       = near_above;
          target_dir   = 1'b1;
          target_found = 1'b1;
        end
      end
    end
  end

  // Call bookkeeping: set on rise, optional toggle-cancel, door clear always wins.
  always_comb begin
    clr = 4'b0000;
    if ((state == DWELL) && floor_valid) begin
      // Clearing the whole current-floor bit also absorbs a reopen press.
      clr = present_floor;
    end
`ifdef FLOOR_CALL_CANCEL_EN
    // The floor currently being driven to cannot be cancelled mid-trip.
    cancel_mask = rise & pending & ((state == MOVE) ? ~requested_floor : 4'b1111);
`else
    cancel_mask = 4'b0000;
`endif
    pending_nxt = ((pending | rise) & ~cancel_mask) & ~clr;
  end

  // Next-state logic with requested floor, direction and dwell counter updates.
  always_comb begin
    state_nxt     = state;
    dwell_cnt_nxt = dwell_cnt;
    req_nxt       = requested_floor;
    dir_nxt       = direction;
    if (!floor_valid) begin
      state_nxt = IDLE;
      req_nxt   = 4'b0001;
    end else begin
      case (state)
        IDLE: begin
          req_nxt = present_floor;
          if (at_call) begin
            state_nxt     = DWELL;
            dwell_cnt_nxt = DWELL_LOAD;
          end else if (pending != 4'b0000) begin
            state_nxt = MOVE;
            dir_nxt   = target_dir;
          end
        end
        MOVE: begin
          if (arrived) begin
            state_nxt     = DWELL;
            dwell_cnt_nxt = DWELL_LOAD;
          end else if (!target_found) begin
            state_nxt = IDLE;
          end else begin
            req_nxt = target;
            dir_nxt = target_dir;
          end
        end
        DWELL: begin
          if (reopen) begin
            dwell_cnt_nxt = DWELL_LOAD;
          end else if (tick) begin
            if (dwell_cnt <= 4'd1) begin
              dwell_cnt_nxt = 4'd0;
              state_nxt     = (pending_nxt != 4'b0000) ? MOVE : IDLE;
              if (target_found) dir_nxt = target_dir;
            end else begin
              dwell_cnt_nxt = dwell_cnt - 4'd1;
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          req_nxt   = 4'b0001;
        end
      endcase
    end
  end

  // State, outputs and call registers; reset drops every outstanding call.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      btn_q           <= 4'b0000;
      pending         <= 4'b0000;
      dwell_cnt       <= 4'd0;
      requested_floor <= 4'b0001;
      direction       <= 1'b1;
    end else begin
      state           <= state_nxt;
      btn_q           <= call_btn;
      pending         <= pending_nxt;
      dwell_cnt       <= dwell_cnt_nxt;
      requested_floor <= req_nxt;
      direction       <= dir_nxt;
    end
  end

endmodule

// File: tb/tb_floor_request_dispatcher.sv
// Purpose: exercises floor_request_dispatcher with directed scenarios and a randomized car plant.
// Latency: compares every output one time unit after each rising edge.
// Backpressure: none; the plant moves the car toward the requested floor at random speed.
module tb_floor_request_dispatcher;

  localparam int DT = 2;
`ifdef FLOOR_CALL_CANCEL_EN
  localparam bit CANCEL = 1'b1;
`else
  localparam bit CANCEL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic [3:0] call_btn = 4'b0000;
  logic [3:0] present_floor = 4'b0001;
  logic [3:0] requested_floor;
  logic [3:0] pending;
  logic       direction;
  logic       busy;
  logic       door_open;

  int n_checks = 0;
  int n_err    = 0;

  floor_request_dispatcher #(.DWELL_TICKS(DT)) dut (
    .clk             (clk),
    .reset           (reset),
    .tick            (tick),
    .call_btn        (call_btn),
    .present_floor   (present_floor),
    .requested_floor (requested_floor),
    .pending         (pending),
    .direction       (direction),
    .busy            (busy),
    .door_open       (door_open)
  );

  always #5 clk = ~clk;

  // Behavioural model: floors as indices, calls as a bit set, door time as tick count.
  typedef enum {M_IDLE, M_MOVE, M_DWELL} mode_t;
  mode_t      m_mode = M_IDLE;
  logic [3:0] m_req  = 4'b0001;
  logic [3:0] m_pend = 4'b0000;
  logic       m_dir  = 1'b1;
  int         m_left = 0;
  logic [3:0] m_btnq = 4'b0000;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Search outward by distance: first in the travel direction, then the other way.
  task automatic find_target(input logic [3:0] pend, input int fi, input logic dir,
                             output logic found, output logic tdir);
    found = 1'b0;
    tdir  = dir;
    for (int d = 1; d < 4; d++) begin
      int f;
      f = dir ? fi + d : fi - d;
      if (!found && f >= 0 && f < 4 && pend[f]) begin
        found = 1'b1;
        tdir  = dir;
      end
    end
    for (int d = 1; d < 4; d++) begin
      int f;
      f = dir ? fi - d : fi + d;
      if (!found && f >= 0 && f < 4 && pend[f]) begin
        found = 1'b1;
        tdir  = ~dir;
      end
    end
  endtask

  task automatic target_floor(input logic [3:0] pend, input int fi, input logic dir,
                              output logic [3:0] tgt);
    logic done;
    done = 1'b0;
    tgt  = 4'b0000;
    for (int d = 1; d < 4; d++) begin
      int f;
      f = dir ? fi + d : fi - d;
      if (!done && f >= 0 && f < 4 && pend[f]) begin done = 1'b1; tgt = 4'b0001 << f; end
    end
    for (int d = 1; d < 4; d++) begin
      int f;
      f = dir ? fi - d : fi + d;
      if (!done && f >= 0 && f < 4 && pend[f]) begin done = 1'b1; tgt = 4'b0001 << f; end
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_edge();
    int         fi;
    logic       valid;
    logic [3:0] rise;
    logic [3:0] np;
    logic       found;
    logic       tdir;
    logic [3:0] tgt;
    if (reset) begin
      m_mode = M_IDLE; m_req = 4'b0001; m_pend = 4'b0000;
      m_dir = 1'b1; m_left = 0; m_btnq = 4'b0000;
      return;
    end
    valid = ($countones(present_floor) == 1);
    fi = 0;
    for (int i = 0; i < 4; i++) if (present_floor[i]) fi = i;
    rise = call_btn & ~m_btnq;
    np = m_pend;
    for (int i = 0; i < 4; i++) begin
      if (rise[i]) begin
        if (CANCEL && m_pend[i] && !(m_mode == M_MOVE && m_req[i])) np[i] = 1'b0;
        else np[i] = 1'b1;
      end
    end
    if (valid && m_mode == M_DWELL) np[fi] = 1'b0;
    find_target(m_pend, fi, m_dir, found, tdir);
    target_floor(m_pend, fi, m_dir, tgt);
    if (!valid) begin
      found = 1'b0;
      m_mode = M_IDLE;
      m_req = 4'b0001;
    end else begin
      case (m_mode)
        M_IDLE: begin
          m_req = present_floor;
          if (m_pend[fi]) begin m_mode = M_DWELL; m_left = DT; end
          else if (m_pend != 4'b0000) begin m_mode = M_MOVE; m_dir = tdir; end
        end
        M_MOVE: begin
          if (m_pend[fi] && present_floor == m_req) begin m_mode = M_DWELL; m_left = DT; end
          else if (!found) m_mode = M_IDLE;
          else begin m_req = tgt; m_dir = tdir; end
        end
        default: begin
          if (rise[fi]) m_left = DT;
          else if (tick) begin
            if (m_left <= 1) begin
              m_left = 0;
              m_mode = (np != 4'b0000) ? M_MOVE : M_IDLE;
              if (found) m_dir = tdir;
            end else m_left = m_left - 1;
          end
        end
      endcase
    end
    m_pend = np;
    m_btnq = call_btn;
  endtask

  // One clock: model advance, edge, then compare every output against the model.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("requested_floor", requested_floor, m_req);
    check("pending", pending, m_pend);
    check("direction", {3'b0, direction}, {3'b0, m_dir});
    check("busy", {3'b0, busy}, {3'b0, (m_mode != M_IDLE)});
    check("door_open", {3'b0, door_open}, {3'b0, (m_mode == M_DWELL)});
  endtask

  task automatic cyc(input logic [3:0] b, input logic t);
    call_btn = b;
    tick = t;
    step();
  endtask

  task automatic pin(input string name, input logic [3:0] act, input logic [3:0] exp);
    check({"pin_", name}, act, exp);
  endtask

  initial begin
    int pf_idx;
    int bad_cnt;
    logic [3:0] bad_pat;
    logic [3:0] bad_tab [4];
    bad_tab[0] = 4'b0000; bad_tab[1] = 4'b0110; bad_tab[2] = 4'b1010; bad_tab[3] = 4'b1111;

    // 1: reset values, then a call to floor 3 from floor 0.
    reset = 1'b1; present_floor = 4'b0001;
    cyc(4'b0000, 1'b0); cyc(4'b0000, 1'b0);
    reset = 1'b0;
    pin("rst_req", m_req, 4'b0001);
    pin("rst_pend", m_pend, 4'b0000);
    pin("rst_dir", {3'b0, m_dir}, 4'b0001);
    pin("rst_busy", {3'b0, m_mode != M_IDLE}, 4'b0000);
    cyc(4'b1000, 1'b0); pin("t1_pend", m_pend, 4'b1000);
    cyc(4'b0000, 1'b0); pin("t1_busy", {3'b0, m_mode != M_IDLE}, 4'b0001);
    cyc(4'b0000, 1'b0); pin("t1_req", m_req, 4'b1000); pin("t1_dir", {3'b0, m_dir}, 4'b0001);

    // 2: call on the way is served first, dwell, then resume.
    cyc(4'b0010, 1'b0); pin("t2_pend", m_pend, 4'b1010);
    cyc(4'b0000, 1'b0); pin("t2_req", m_req, 4'b0010);
    present_floor = 4'b0010;
    cyc(4'b0000, 1'b0); pin("t2_door", {3'b0, m_mode == M_DWELL}, 4'b0001);
    cyc(4'b0000, 1'b0); pin("t2_clr", m_pend, 4'b1000);
    cyc(4'b0000, 1'b1); pin("t2_door_t1", {3'b0, m_mode == M_DWELL}, 4'b0001);
    cyc(4'b0000, 1'b1); pin("t2_door_t2", {3'b0, m_mode == M_DWELL}, 4'b0000);
    cyc(4'b0000, 1'b0); pin("t2_resume", m_req, 4'b1000);
    present_floor = 4'b0100; cyc(4'b0000, 1'b0);
    present_floor = 4'b1000; cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b0); cyc(4'b0000, 1'b1); cyc(4'b0000, 1'b1);
    pin("t2_idle", {3'b0, m_mode != M_IDLE}, 4'b0000);

    // 3: at floor 2 heading up, only floor 0 pending: direction flips.
    present_floor = 4'b0100; cyc(4'b0000, 1'b0);
    cyc(4'b0001, 1'b0);
    cyc(4'b0000, 1'b0); pin("t3_dir", {3'b0, m_dir}, 4'b0000);
    cyc(4'b0000, 1'b0); pin("t3_req", m_req, 4'b0001);
    present_floor = 4'b0010; cyc(4'b0000, 1'b0);
    present_floor = 4'b0001; cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b0); cyc(4'b0000, 1'b1); cyc(4'b0000, 1'b1);

    // 4: call at the current floor opens the door; a repeat press reloads the dwell.
    present_floor = 4'b0010; cyc(4'b0000, 1'b0);
    cyc(4'b0010, 1'b0);
    cyc(4'b0010, 1'b0); pin("t4_door", {3'b0, m_mode == M_DWELL}, 4'b0001);
    cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b1);
    cyc(4'b0010, 1'b0); pin("t4_absorb", m_pend, 4'b0000);
    cyc(4'b0000, 1'b1); pin("t4_reload", {3'b0, m_mode == M_DWELL}, 4'b0001);
    cyc(4'b0000, 1'b1); pin("t4_close", {3'b0, m_mode == M_DWELL}, 4'b0000);

    // 5: invalid floor reports hold IDLE; reset mid-move.
    present_floor = 4'b0000;
    cyc(4'b1000, 1'b0); pin("t5_req", m_req, 4'b0001); pin("t5_pend", m_pend, 4'b1000);
    present_floor = 4'b0110;
    cyc(4'b0000, 1'b0); pin("t5_busy", {3'b0, m_mode != M_IDLE}, 4'b0000);
    present_floor = 4'b0010; cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b0); pin("t5_move", m_req, 4'b1000);
    reset = 1'b1; cyc(4'b0000, 1'b0); reset = 1'b0;
    pin("t5_rst_pend", m_pend, 4'b0000); pin("t5_rst_req", m_req, 4'b0001);

`ifdef FLOOR_CALL_CANCEL_EN
    // 6: toggle-cancel of a non-target call; the active target is protected.
    present_floor = 4'b0100; cyc(4'b0000, 1'b0);
    cyc(4'b1000, 1'b0); cyc(4'b0000, 1'b0); cyc(4'b0000, 1'b0);
    cyc(4'b0100, 1'b0); cyc(4'b0000, 1'b0);
    cyc(4'b0100, 1'b0); pin("t6_cancel", m_pend, 4'b1000);
    cyc(4'b0000, 1'b0);
    cyc(4'b1000, 1'b0); pin("t6_keep", m_pend, 4'b1000); pin("t6_req", m_req, 4'b1000);
    cyc(4'b0000, 1'b0);
`endif

    // Random phase: toggling buttons, random ticks, a plant that drifts toward the target.
    reset = 1'b1; present_floor = 4'b0001; cyc(4'b0000, 1'b0); reset = 1'b0;
    pf_idx = 0; bad_cnt = 0; bad_pat = 4'b0000;
    for (int n = 0; n < 4000; n++) begin
      reset = ($urandom_range(0, 699) == 0);
      tick = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 11) == 0) call_btn[i] = ~call_btn[i];
      if (bad_cnt > 0) begin
        bad_cnt--;
        present_floor = bad_pat;
      end else if ($urandom_range(0, 149) == 0) begin
        bad_cnt = 2;
        bad_pat = bad_tab[$urandom_range(0, 3)];
        present_floor = bad_pat;
      end else begin
        if (m_mode == M_MOVE && $urandom_range(0, 3) == 0) begin
          int ti;
          ti = pf_idx;
          for (int i = 0; i < 4; i++) if (m_req[i]) ti = i;
          if (ti > pf_idx) pf_idx++;
          else if (ti < pf_idx) pf_idx--;
        end
        present_floor = 4'b0001 << pf_idx;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
